mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl_pkg.sv | 18 +
 rtl/mem_access_ctrl_if.sv | 21 ++
 rtl/mem_access_ctrl_wb_mux.sv | 22 ++
 rtl/mem_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the memory-access / writeback sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus; master = sequencer, slave = memory.
interface mem_access_ctrl_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_access_ctrl_wb_mux.sv
// Combinational 4:1 writeback-source select; the reserved encoding yields zero.
module wb_mux
  import mem_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] mem_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = '0;
    case (sel_i)
      WB_ALU:  data_o = alu_i;
      WB_MEM:  data_o = mem_i;
      WB_PC4:  data_o = pc4_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer with pipeline stall and register-file writeback.
// Optional WAIT-state abort on missing ack is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reg_wrff,
  input  logic                     rd_enff,
  input  logic                     wr_enff,
  input  logic [1:0]               wb_selff,
  input  logic [31:0]              alu_res,
  input  logic [31:0]              store_data,
  input  logic [31:0]              pc_plus4,
  input  logic [4:0]               rd_addr,
  mem_access_ctrl_if.master        dmem,
  output logic                     stall,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     mem_err
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_buf_q, load_buf_d;
  logic        err_q, err_d;
  logic        mem_op;
  logic        timeout_hit;
  logic        wb_allowed;
  logic [31:0] mem_src;
  logic        unused_addr_lsbs;

  assign mem_op           = rd_enff | wr_enff;
  assign unused_addr_lsbs = ^alu_res[1:0];

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counter is held at zero outside WAIT so it is already clear on entry.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_WAIT) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end

  assign timeout_hit = (state_q == S_WAIT) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign mem_err     = err_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_buf_d = load_buf_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          we_d    = wr_enff;
          addr_d  = {alu_res[31:2], 2'b00};
          wdata_d = store_data;
        end
      end
      S_WAIT: begin
        // An ack arriving on the expiry cycle still completes the access.
        if (dmem.dmem_ack) begin
          state_d    = S_DONE;
          req_d      = 1'b0;
          load_buf_d = dmem.dmem_rdata;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      load_buf_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      load_buf_q <= load_buf_d;
      err_q      <= err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  // Loaded data is only meaningful in DONE after a read; a store never writes back from memory.
  assign mem_src = (state_q == S_DONE && !we_q) ? load_buf_q : 32'd0;

  wb_mux u_wb_mux (
    .sel_i  (wb_selff),
    .alu_i  (alu_res),
    .mem_i  (mem_src),
    .pc4_i  (pc_plus4),
    .data_o (rf_wdata)
  );

  assign wb_allowed = reg_wrff && (rd_addr != 5'd0);

  always_comb begin
    stall = 1'b0;
    rf_we = 1'b0;
    if (reset) begin
      case (state_q)
        S_IDLE: begin
          stall = mem_op;
          rf_we = !mem_op && wb_allowed;
        end
        S_WAIT:  stall = 1'b1;
        S_DONE:  rf_we = wb_allowed && !err_q && !(we_q && wb_selff == WB_MEM);
        default: stall = 1'b0;
      endcase
    end
  end

  assign rf_waddr = rd_addr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT_CYCLES = 4).
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_wrff, rd_enff, wr_enff;
  logic [1:0]  wb_selff;
  logic [31:0] alu_res, store_data, pc_plus4;
  logic [4:0]  rd_addr;
  logic        stall, rf_we, mem_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl_if dmem_bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_wrff   (reg_wrff),
    .rd_enff    (rd_enff),
    .wr_enff    (wr_enff),
    .wb_selff   (wb_selff),
    .alu_res    (alu_res),
    .store_data (store_data),
    .pc_plus4   (pc_plus4),
    .rd_addr    (rd_addr),
    .dmem       (dmem_bus),
    .stall      (stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic rd, input logic wr, input logic [1:0] sel,
                       input logic [4:0] rda, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [31:0] pc4);
    reg_wrff   = rw;
    rd_enff    = rd;
    wr_enff    = wr;
    wb_selff   = sel;
    rd_addr    = rda;
    alu_res    = alu;
    store_data = sd;
    pc_plus4   = pc4;
  endtask

  // Issues one memory instruction from IDLE, acks in WAIT cycle ack_at (0 = never),
  // and returns the stall-cycle count and the DONE-cycle writeback/err outputs.
  task automatic mem_op(input logic rw, input logic rd, input logic wr, input logic [1:0] sel,
                        input logic [4:0] rda, input logic [31:0] alu, input logic [31:0] sd,
                        input int ack_at, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic exp_we,
                        input logic [31:0] exp_wdata, input string name,
                        output int stalls, output logic d_we,
                        output logic [31:0] d_wdata, output logic d_err);
    int n;
    int bad;
    @(negedge clk);
    drive(rw, rd, wr, sel, rda, alu, sd, 32'h0000_0040);
    dmem_bus.dmem_ack = 1'b0;
    #1;
    stalls = int'(stall);
    check({name, "_idle_rf_we"}, 32'(rf_we), 32'd0);
    n   = 0;
    bad = 0;
    while (n < 40) begin
      @(negedge clk);
      dmem_bus.dmem_ack = 1'b0;
      #1;
      if (!dmem_bus.dmem_req) break;
      n++;
      stalls += int'(stall);
      if (dmem_bus.dmem_addr !== exp_addr || dmem_bus.dmem_we !== exp_we ||
          dmem_bus.dmem_wdata !== exp_wdata || stall !== 1'b1)
        bad++;
      if (n == ack_at) begin
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = rdata;
      end
    end
    check({name, "_wait_bounded"}, 32'(n < 40), 32'd1);
    check({name, "_wait_bus_stable"}, 32'(bad), 32'd0);
    stalls += int'(stall);
    d_we    = rf_we;
    d_wdata = rf_wdata;
    d_err   = mem_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stalls;
    logic        d_we, d_err;
    logic [31:0] d_wdata;

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);

    // Reset state, with a would-be write and a would-be memory op on the inputs
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
    #1;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
    check("rst_addr", dmem_bus.dmem_addr, 32'd0);
    check("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);

    // ALU writeback, zero latency
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
    #1;
    check("alu_rf_we", 32'(rf_we), 32'd1);
    check("alu_rf_waddr", 32'(rf_waddr), 32'd5);
    check("alu_rf_wdata", rf_wdata, 32'h0000_1234);
    check("alu_stall", 32'(stall), 32'd0);
    wb_selff = 2'd3;
    #1;
    check("reserved_sel_wdata", rf_wdata, 32'd0);
    wb_selff = 2'd1;
    #1;
    check("idle_mem_sel_wdata", rf_wdata, 32'd0);

    // Misaligned load, ack in first WAIT cycle
    mem_op(1'b1, 1'b1, 1'b0, 2'd1, 5'd7, 32'h0000_0103, 32'h1111_1111, 1, 32'hCAFE_F00D,
           32'h0000_0100, 1'b0, 32'h1111_1111, "load", stalls, d_we, d_wdata, d_err);
    $display("load: stalls=%0d rf_we=%0b rf_wdata=0x%08h", stalls, d_we, d_wdata);
    check("load_stalls", 32'(stalls), 32'd2);
    check("load_done_rf_we", 32'(d_we), 32'd1);
    check("load_done_wdata", d_wdata, 32'hCAFE_F00D);
    check("load_done_req", 32'(dmem_bus.dmem_req), 32'd0);

    // Store, ack in 4th WAIT cycle
    mem_op(1'b0, 1'b0, 1'b1, 2'd0, 5'd0, 32'h0000_2000, 32'hA5A5_A5A5, 4, 32'h0,
           32'h0000_2000, 1'b1, 32'hA5A5_A5A5, "store", stalls, d_we, d_wdata, d_err);
    $display("store: stalls=%0d rf_we=%0b", stalls, d_we);
    check("store_stalls", 32'(stalls), 32'd5);
    check("store_done_rf_we", 32'(d_we), 32'd0);

    // Load and store both set: store wins, no memory writeback
    mem_op(1'b1, 1'b1, 1'b1, 2'd1, 5'd3, 32'h0000_0208, 32'h0BAD_CAFE, 1, 32'h1357_9BDF,
           32'h0000_0208, 1'b1, 32'h0BAD_CAFE, "rdwr", stalls, d_we, d_wdata, d_err);
    $display("rdwr: stalls=%0d rf_we=%0b", stalls, d_we);
    check("rdwr_done_rf_we", 32'(d_we), 32'd0);

    // Load to x0, then JAL
    mem_op(1'b1, 1'b1, 1'b0, 2'd1, 5'd0, 32'h0000_0300, 32'h0, 1, 32'hDEAD_BEEF,
           32'h0000_0300, 1'b0, 32'h0, "load_x0", stalls, d_we, d_wdata, d_err);
    $display("load_x0: stalls=%0d rf_we=%0b", stalls, d_we);
    check("load_x0_rf_we", 32'(d_we), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'd2, 5'd1, 32'h0000_9999, 32'h0, 32'h0000_0044);
    #1;
    $display("jal: rf_we=%0b rf_waddr=%0d rf_wdata=0x%08h", rf_we, rf_waddr, rf_wdata);
    check("jal_rf_we", 32'(rf_we), 32'd1);
    check("jal_rf_waddr", 32'(rf_waddr), 32'd1);
    check("jal_rf_wdata", rf_wdata, 32'h0000_0044);

    // Reset in the 2nd WAIT cycle, then a late ack
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 5'd9, 32'h0000_0400, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check("rstwait_req_w1", 32'(dmem_bus.dmem_req), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstwait_stall_in_rst", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h0BAD_0BAD;
    #1;
    $display("reset_in_wait: req=%0b stall=%0b addr=0x%08h", dmem_bus.dmem_req, stall,
             dmem_bus.dmem_addr);
    check("rstwait_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rstwait_stall", 32'(stall), 32'd0);
    check("rstwait_addr", dmem_bus.dmem_addr, 32'd0);
    @(negedge clk);
    dmem_bus.dmem_ack = 1'b0;
    #1;
    check("late_ack_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("late_ack_stall", 32'(stall), 32'd0);
    check("late_ack_mem_err", 32'(mem_err), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 WAIT cycles
    mem_op(1'b1, 1'b1, 1'b0, 2'd1, 5'd4, 32'h0000_0500, 32'h0, 0, 32'h0,
           32'h0000_0500, 1'b0, 32'h0, "timeout", stalls, d_we, d_wdata, d_err);
    $display("timeout: stalls=%0d rf_we=%0b mem_err=%0b", stalls, d_we, d_err);
    check("timeout_stalls", 32'(stalls), 32'd5);
    check("timeout_mem_err", 32'(d_err), 32'd1);
    check("timeout_rf_we", 32'(d_we), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    check("timeout_err_clears", 32'(mem_err), 32'd0);
    check("timeout_back_idle", 32'(stall), 32'd0);
    // Ack on the expiry cycle wins
    mem_op(1'b1, 1'b1, 1'b0, 2'd1, 5'd4, 32'h0000_0600, 32'h0, 4, 32'h0000_600D,
           32'h0000_0600, 1'b0, 32'h0, "ack_wins", stalls, d_we, d_wdata, d_err);
    $display("ack_wins: stalls=%0d rf_we=%0b mem_err=%0b wdata=0x%08h", stalls, d_we, d_err, d_wdata);
    check("ack_wins_mem_err", 32'(d_err), 32'd0);
    check("ack_wins_rf_we", 32'(d_we), 32'd1);
    check("ack_wins_wdata", d_wdata, 32'h0000_600D);
`else
    // Without the timeout the access simply waits for the ack
    mem_op(1'b1, 1'b1, 1'b0, 2'd1, 5'd4, 32'h0000_0500, 32'h0, 6, 32'h7777_8888,
           32'h0000_0500, 1'b0, 32'h0, "long_wait", stalls, d_we, d_wdata, d_err);
    $display("long_wait: stalls=%0d rf_we=%0b mem_err=%0b", stalls, d_we, d_err);
    check("long_wait_stalls", 32'(stalls), 32'd7);
    check("long_wait_mem_err", 32'(d_err), 32'd0);
    check("long_wait_wdata", d_wdata, 32'h7777_8888);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
